// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART transmitter among four byte-stream requesters.
// Optional mid-packet stall abort is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_byte,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting
);

    typedef enum logic [1:0] {IDLE, SEND, BUSY, DRAIN} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        transmit_q, transmit_d;
    logic        last_q, last_d;
    logic [1:0]  pick;
    logic        found;
    logic        accept;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        pick  = last_grant_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req_valid[last_grant_q + 2'(k)]) begin
                pick  = last_grant_q + 2'(k);
                found = 1'b1;
            end
        end
    end

    assign accept    = (state_q == SEND) && req_valid[grant_q] && !is_transmitting;
    assign req_ready = accept ? (4'b1 << grant_q) : 4'b0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tx_byte_d    = tx_byte_q;
        transmit_d   = transmit_q;
        last_d       = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        first_d       = first_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    first_d = 1'b1;
                    cnt_d   = '0;
`endif
                end
            end
            SEND: begin
                if (accept) begin
                    tx_byte_d  = req_byte[{grant_q, 3'b000} +: 8];
                    transmit_d = 1'b1;
                    last_d     = req_last[grant_q];
                    state_d    = BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    first_d    = 1'b0;
                    cnt_d      = '0;
                end else if (!first_q && !req_valid[grant_q]) begin
                    // Stalled requester mid-packet: abort and hand the line to the next one.
                    if (cnt_q == CNT_MAX) begin
                        timeout_err_d = 1'b1;
                        last_grant_d  = grant_q;
                        cnt_d         = '0;
                        state_d       = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            BUSY: begin
                if (is_transmitting) begin
                    transmit_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!is_transmitting) begin
                    if (last_q) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            tx_byte_q    <= 8'd0;
            transmit_q   <= 1'b0;
            last_q       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            first_q       <= 1'b0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tx_byte_q    <= tx_byte_d;
            transmit_q   <= transmit_d;
            last_q       <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet queues per requester, a UART core model, and a
// packet-level reference checked every cycle plus directed literal expectations.
module tb_uart_tx_arbiter;
    localparam int TMO = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_byte = '0;
    logic [3:0]  req_last = '0;
    logic        is_transmitting = 1'b0;
    logic [3:0]  req_ready;
    logic [1:0]  grant;
    logic        busy, timeout_err, transmit;
    logic [7:0]  tx_byte;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_byte(req_byte),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
        .timeout_err(timeout_err), .transmit(transmit), .tx_byte(tx_byte),
        .is_transmitting(is_transmitting)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 50) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester packet queues: bit 8 marks the last byte of a packet.
    logic [8:0] rq [4][$];
    logic [7:0] line_log [$];
    logic [7:0] exp_line [$];
    int         grant_log [$];
    int         rdy_cnt [4] = '{0, 0, 0, 0};
    bit         rnd_mode = 1'b0;
    logic [3:0] acc_mask = '0;
    logic       tx_seen = 1'b0;
    int         frame_left = 0;

    // Reference: packet phase 0 idle, 1 waiting for a byte, 2 byte handed over, 3 frame on line.
    int         m_ph = 0, m_g = 0, m_lastg = 3, m_cnt = 0;
    logic       m_tx = 0, m_terr = 0, m_first = 0, m_lastflag = 0;
    logic [7:0] m_byte = 0;

    function automatic int rr_pick(int last, logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int j = (last + k) % 4;
            if (v[j]) return j;
        end
        return last;
    endfunction

    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        exp_rdy = (m_ph == 1 && req_valid[m_g] && !is_transmitting) ? (4'b1 << m_g) : 4'b0;
        chk("busy", busy, m_ph != 0);
        chk("grant", grant, m_g);
        chk("transmit", transmit, m_tx);
        chk("tx_byte", tx_byte, m_byte);
        chk("timeout_err", timeout_err, m_terr);
        chk("req_ready", req_ready, exp_rdy);
        acc_mask = req_ready;
        tx_seen  = transmit && rst_n;
        for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i]++;
        if (!rst_n) begin
            m_ph <= 0; m_g <= 0; m_lastg <= 3; m_tx <= 0; m_byte <= 0;
            m_terr <= 0; m_cnt <= 0; m_first <= 0; m_lastflag <= 0;
            exp_line.delete();
        end else begin
            m_terr <= 0;
            case (m_ph)
                0: if (|req_valid) begin
                    int nxt;
                    nxt = rr_pick(m_lastg, req_valid);
                    m_g <= nxt; grant_log.push_back(nxt);
                    m_ph <= 1; m_first <= 1; m_cnt <= 0;
                end
                1: if (exp_rdy != 0) begin
                    m_byte <= req_byte[8*m_g +: 8];
                    exp_line.push_back(req_byte[8*m_g +: 8]);
                    m_tx <= 1; m_lastflag <= req_last[m_g];
                    m_ph <= 2; m_first <= 0; m_cnt <= 0;
                end else if (TMO_ON && !m_first && !req_valid[m_g]) begin
                    if (m_cnt + 1 == TMO) begin
                        m_terr <= 1; m_lastg <= m_g; m_cnt <= 0; m_ph <= 0;
                    end else m_cnt <= m_cnt + 1;
                end
                2: if (is_transmitting) begin m_tx <= 0; m_ph <= 3; end
                default: if (!is_transmitting) begin
                    if (m_lastflag) begin m_lastg <= m_g; m_ph <= 0; end
                    else m_ph <= 1;
                end
            endcase
        end
    end

    // One clock: advance the UART core model, then the requesters.
    task automatic step();
        @(posedge clk); #1;
        if (is_transmitting) begin
            frame_left--;
            if (frame_left == 0) is_transmitting = 1'b0;
        end else if (tx_seen && (!rnd_mode || $urandom_range(2) != 0)) begin
            is_transmitting = 1'b1;
            frame_left = $urandom_range(6, 2);
            line_log.push_back(tx_byte);
            if (exp_line.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL line_byte: got %0h expected none at %0t", tx_byte, $time);
            end else chk("line_byte", tx_byte, exp_line.pop_front());
        end
        for (int i = 0; i < 4; i++)
            if (acc_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0 && (!rnd_mode || $urandom_range(99) < 85)) begin
                req_valid[i] = 1'b1;
                req_byte[8*i +: 8] = rq[i][0][7:0];
                req_last[i] = rq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_byte[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
    endtask

    task automatic wait_done(int limit, string name);
        for (int n = 0; n < limit; n++) begin
            if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0
                && !busy && !is_transmitting && !transmit) begin
                chk({name, "_line_drained"}, exp_line.size(), 0);
                return;
            end
            step();
        end
        n_cmp++; n_bad++;
        $display("FAIL %s: timed out after %0d cycles", name, limit);
    endtask

    initial begin
        int gl0, ll0, r2, k;
        bit terr_seen;
        logic [7:0] exp_l2 [10];
        int         exp_g2 [5];
        logic [7:0] exp_l3 [4];
        exp_l2 = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h08, 8'h09};
        exp_g2 = '{0, 1, 2, 3, 0};
        exp_l3 = '{8'h10, 8'h11, 8'h12, 8'h20};

        repeat (3) step();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_transmit", transmit, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;

        // Single one-byte packet from requester 2.
        gl0 = grant_log.size(); ll0 = line_log.size(); r2 = rdy_cnt[2];
        rq[2].push_back({1'b1, 8'h41});
        wait_done(200, "single");
        chk("single_ngrants", grant_log.size() - gl0, 1);
        chk("single_grant", grant_log[gl0], 2);
        chk("single_line", line_log[ll0], 8'h41);
        chk("single_ready_pulses", rdy_cnt[2] - r2, 1);
        chk("single_grant_out", grant, 2);
        chk("single_busy", busy, 0);

        // Round-robin from reset with all four requesters holding two-byte packets.
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        gl0 = grant_log.size(); ll0 = line_log.size();
        for (int i = 0; i < 4; i++) begin
            rq[i].push_back({1'b0, 8'(16*i)});
            rq[i].push_back({1'b1, 8'(16*i + 1)});
        end
        rq[0].push_back({1'b0, 8'h08});
        rq[0].push_back({1'b1, 8'h09});
        wait_done(2000, "rr");
        for (int i = 0; i < 5; i++) chk("rr_grant_order", grant_log[gl0+i], exp_g2[i]);
        for (int i = 0; i < 10; i++) chk("rr_line", line_log[ll0+i], exp_l2[i]);

        // Atomicity: requester 1 three-byte packet with requester 0 waiting.
        gl0 = grant_log.size(); ll0 = line_log.size();
        rq[1].push_back({1'b0, 8'h10});
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b1, 8'h12});
        rq[0].push_back({1'b1, 8'h20});
        wait_done(2000, "atomic");
        chk("atomic_grant0", grant_log[gl0], 1);
        chk("atomic_grant1", grant_log[gl0+1], 0);
        for (int i = 0; i < 4; i++) chk("atomic_line", line_log[ll0+i], exp_l3[i]);

        // Reset while a byte is being handed to the core.
        rq[1].push_back({1'b0, 8'h50});
        rq[1].push_back({1'b1, 8'h51});
        k = 0;
        while (!transmit && k < 200) begin step(); k++; end
        chk("rstmid_reached_busy", transmit, 1);
        rst_n = 1'b0; rq[1].delete();
        step();
        chk("rstmid_transmit", transmit, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_grant", grant, 0);
        rst_n = 1'b1;
        gl0 = grant_log.size();
        rq[0].push_back({1'b1, 8'h60});
        rq[3].push_back({1'b1, 8'h63});
        wait_done(2000, "rstmid");
        chk("rstmid_first_grant", grant_log[gl0], 0);
        chk("rstmid_second_grant", grant_log[gl0+1], 3);

        // Requester 3 stalls after its first byte while requester 0 waits.
        gl0 = grant_log.size(); ll0 = line_log.size();
        rq[3].push_back({1'b0, 8'h33});
        k = 0;
        while (grant_log.size() == gl0 && k < 50) begin step(); k++; end
        rq[0].push_back({1'b1, 8'h05});
        k = 0;
        while (!(line_log.size() > ll0 && !is_transmitting) && k < 200) begin step(); k++; end
        chk("stall_first_byte", line_log[ll0], 8'h33);
`ifdef UART_ARB_TIMEOUT_EN
        k = 0;
        while (k < 100) begin step(); k++; if (timeout_err) break; end
        chk("timeout_latency", k, TMO + 1);
        wait_done(2000, "timeout");
`else
        terr_seen = 1'b0;
        repeat (1000) begin step(); if (timeout_err) terr_seen = 1'b1; end
        chk("stall_grant", grant, 3);
        chk("stall_busy", busy, 1);
        chk("stall_no_timeout", terr_seen, 0);
        rq[3].push_back({1'b1, 8'h34});
        wait_done(2000, "stall");
`endif
        chk("stall_grant_a", grant_log[gl0], 3);
        chk("stall_grant_b", grant_log[gl0+1], 0);
        chk("stall_last_line", line_log[line_log.size()-1], 8'h05);

        // Randomized packets, valid gaps and core start delays.
        rnd_mode = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int who, len;
            who = $urandom_range(3);
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) rq[who].push_back({1'(b == len - 1), 8'($urandom)});
        end
        wait_done(40000, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
